// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_det_pkg
//  Purpose  : Shared types, constants and helpers for the serial pattern
//             detector family.
//  Contents : seq_det_len_w() - width needed to hold a length 0..max_len
//             C_DEF_PAT       - power-on pattern "010", right-aligned
//             C_DEF_LEN       - power-on pattern length (3)
//             C_MAX_LEN_LIMIT - widest pattern the family supports
//  Revision : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

  // Widest pattern that any instance may be built for.
  localparam int C_MAX_LEN_LIMIT = 16;

  // Power-on configuration: the legacy fixed "010" detector.
  localparam logic [C_MAX_LEN_LIMIT-1:0] C_DEF_PAT = 16'b010;
  localparam int                         C_DEF_LEN = 3;

  // Bits needed to represent every length from 0 up to and including max_len.
  function automatic int seq_det_len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/seq_match_counter.sv
`default_nettype none
// ============================================================================
//  Module   : seq_match_counter
//  Purpose  : Saturating event counter with synchronous clear and a sticky
//             saturation flag. Shared by the detector and monitor blocks.
//  Ports    : clk     - clock, rising edge
//             rst     - synchronous active-high reset
//             i_clr   - zero the count and the saturation flag
//             i_inc   - count one event
//             o_count - current count
//             o_sat   - sticky: count has reached its all-ones maximum
//  Revision : 1.0 - initial release
// ============================================================================
module seq_match_counter #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count,
  output logic             o_sat
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic [CNT_W-1:0] r_count;
  logic             r_sat;
  logic [CNT_W-1:0] w_count_n;

  // A clear coinciding with an event lands on 1, so that event is not lost.
  always_comb begin
    w_count_n = r_count;
    if (i_clr) begin
      w_count_n = i_inc ? CNT_W'(1) : '0;
    end else if (i_inc && (r_count != C_CNT_MAX)) begin
      w_count_n = r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_count <= w_count_n;
      // Flag tracks the value being loaded so it rises with the count itself.
      r_sat   <= (i_clr ? 1'b0 : r_sat) | (w_count_n == C_CNT_MAX);
    end
  end

  assign o_count = r_count;
  assign o_sat   = r_sat;

endmodule : seq_match_counter
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detector_param
//  Purpose  : Serial pattern detector for a 1-bit stream with a runtime
//             programmable pattern of 1..MAX_LEN bits, overlapping or
//             non-overlapping matching, an input qualifier and a saturating
//             match counter. Powers up as a "010" detector.
//  Ports    : clk, rst    - clock / synchronous active-high reset
//             x, x_valid  - serial bit and its qualifier
//             overlap     - 1 = overlapping matches, 0 = non-overlapping
//             cfg_we      - load cfg_pat / cfg_len
//             cfg_pat     - pattern, right-aligned; pat[len-1] arrives first
//             cfg_len     - pattern length, legal range 1..MAX_LEN
//             cnt_clr     - clear match_count and cnt_sat
//             y           - registered one-cycle match pulse
//             match_count - matches since reset or clear (saturating)
//             cnt_sat     - sticky counter-saturated flag
//             cfg_err     - one-cycle pulse on a rejected configuration write
//  Revision : 1.0 - initial release
// ============================================================================
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN = 8,
  parameter int                 CNT_W   = 10,
  parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(C_DEF_PAT),
  parameter int                 RST_LEN = C_DEF_LEN,
  parameter int                 LEN_W   = seq_det_len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  input  logic               x_valid,
  input  logic               overlap,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cnt_clr,
  output logic               y,
  output logic [CNT_W-1:0]   match_count,
  output logic               cnt_sat,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] C_LEN_MAX = LEN_W'(MAX_LEN);

  // Configuration and stream state
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_y;
  logic               r_cfg_err;

  logic               w_cfg_ok;
  logic               w_cfg_bad;
  logic               w_accept;
  logic [MAX_LEN-1:0] w_hist_n;
  logic [LEN_W-1:0]   w_fill_n;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_bits_eq;
  logic               w_hit;

  // A legal write takes priority over the data bit of the same cycle; an
  // illegal one is dropped and leaves the stream untouched.
  assign w_cfg_ok  = cfg_we && (cfg_len != '0) && (cfg_len <= C_LEN_MAX);
  assign w_cfg_bad = cfg_we && !w_cfg_ok;
  assign w_accept  = x_valid && !w_cfg_ok;

  // Newest bit enters at bit 0 so hist[len-1:0] lines up with pat[len-1:0].
  assign w_hist_n = {r_hist[MAX_LEN-2:0], x};
  assign w_fill_n = (r_fill == C_LEN_MAX) ? r_fill : (r_fill + LEN_W'(1));

  // Select only the low len bits for comparison; pattern bits above len
  // are don't-care.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    assign w_mask[gi] = (r_len > LEN_W'(gi));
  end

  assign w_bits_eq = (((w_hist_n ^ r_pat) & w_mask) == '0);
  assign w_hit     = w_accept && (w_fill_n >= r_len) && w_bits_eq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat     <= RST_PAT;
      r_len     <= LEN_W'(RST_LEN);
      r_hist    <= '0;
      r_fill    <= '0;
      r_y       <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_cfg_bad;
      if (w_cfg_ok) begin
        r_pat  <= cfg_pat;
        r_len  <= cfg_len;
        r_hist <= '0;
        r_fill <= '0;
        r_y    <= 1'b0;
      end else if (w_accept) begin
        r_hist <= w_hist_n;
        // Non-overlapping mode restarts the window so the next match needs
        // a full set of fresh bits.
        r_fill <= (w_hit && !overlap) ? '0 : w_fill_n;
        r_y    <= w_hit;
      end else begin
        r_y    <= 1'b0;
      end
    end
  end

  seq_match_counter #(
    .CNT_W   (CNT_W)
  ) u_match_counter (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (cnt_clr),
    .i_inc   (w_hit),
    .o_count (match_count),
    .o_sat   (cnt_sat)
  );

  assign y       = r_y;
  assign cfg_err = r_cfg_err;

endmodule : seq_detector_param
`default_nettype wire
